run_detect_param: RTL and testbench

Parametrised run-length detector for a serial bit stream. Counts consecutive identical samples of `x` and flags when a run of ones, zeros or either reaches a programmable length. It generalises the fixed three-in-a-row sequence detector. It sits behind serial input front-ends as a line-idle and stuck-bit monitor feeding status and interrupt logic.

---
 rtl/run_detect_param.sv | 99 +++++++++
 tb/tb_run_detect_param.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/run_detect_param.sv
// Parametrised run-length detector with ones/zeros/either arming.
// Define RUN_DETECT_EVENT_CNT_EN to build the saturating hit event counter.
module run_detect_param #(
  parameter int CNT_W = 4,
  parameter int EVT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             x,
  input  logic [CNT_W-1:0] run_len,
  input  logic [1:0]       mode,
  input  logic             clr,
  output logic             y,
  output logic             hit,
  output logic             run_bit,
  output logic [CNT_W-1:0] run_cnt,
  output logic [EVT_W-1:0] event_cnt
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] COUNT = 2'd1;
  localparam logic [1:0] HIT   = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]       state, state_n;
  logic             bit_n;
  logic [CNT_W-1:0] cnt_n;
  logic [CNT_W-1:0] thr;
  logic             adv;
  logic             armed;
  logic             y_n;
  logic             hit_n;

  assign thr = (run_len == '0) ? CNT_ONE : run_len;

  // adv marks a sample that actually moved the count, so a saturated
  // run sitting at threshold cannot pulse hit again.
  always_comb begin
    state_n = state;
    bit_n   = run_bit;
    cnt_n   = run_cnt;
    adv     = 1'b0;
    if (en) begin
      if (state == IDLE || x != run_bit) begin
        bit_n = x;
        cnt_n = CNT_ONE;
        adv   = 1'b1;
      end else if (run_cnt != CNT_MAX) begin
        cnt_n = run_cnt + CNT_ONE;
        adv   = 1'b1;
      end
      state_n = (cnt_n >= thr) ? HIT : COUNT;
    end
  end

  assign armed = mode[bit_n];
  assign y_n   = (state_n == HIT) && armed;
  assign hit_n = adv && armed && (cnt_n == thr);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      run_bit <= 1'b0;
      run_cnt <= '0;
      y       <= 1'b0;
      hit     <= 1'b0;
    end else if (clr) begin
      state   <= IDLE;
      run_bit <= 1'b0;
      run_cnt <= '0;
      y       <= 1'b0;
      hit     <= 1'b0;
    end else begin
      state   <= state_n;
      run_bit <= bit_n;
      run_cnt <= cnt_n;
      hit     <= hit_n;
      if (en) y <= y_n;
    end
  end

`ifdef RUN_DETECT_EVENT_CNT_EN
  localparam logic [EVT_W-1:0] EVT_MAX = '1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      event_cnt <= '0;
    end else if (!clr && hit_n && event_cnt != EVT_MAX) begin
      event_cnt <= event_cnt + EVT_W'(1);
    end
  end
`else
  assign event_cnt = '0;
`endif

endmodule

// File: tb/tb_run_detect_param.sv
// Table-driven scoreboard bench for run_detect_param.
// Expected event counts follow RUN_DETECT_EVENT_CNT_EN.
module tb_run_detect_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        x;
  logic [3:0]  run_len;
  logic [1:0]  mode;
  logic        clr;
  logic        y;
  logic        hit;
  logic        run_bit;
  logic [3:0]  run_cnt;
  logic [15:0] event_cnt;

  run_detect_param #(.CNT_W(4), .EVT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .x(x),
    .run_len(run_len), .mode(mode), .clr(clr),
    .y(y), .hit(hit), .run_bit(run_bit),
    .run_cnt(run_cnt), .event_cnt(event_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       clr;
    logic       en;
    logic       x;
    logic [3:0] len;
    logic [1:0] mode;
    logic       y;
    logic       h;
    logic       rb;
    logic [3:0] cnt;
  } vec_t;

  typedef struct {
    int         step;
    logic       y;
    logic       h;
    logic       rb;
    logic [3:0] cnt;
    int         evt;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;
  int   exp_evt = 0;
  int   step = 0;

  function automatic vec_t mk(
    input logic r, input logic c, input logic e, input logic xi,
    input logic [3:0] l, input logic [1:0] m,
    input logic ey, input logic eh, input logic erb, input logic [3:0] ec
  );
    vec_t v;
    v.rst_n = r; v.clr = c; v.en = e; v.x = xi;
    v.len = l; v.mode = m;
    v.y = ey; v.h = eh; v.rb = erb; v.cnt = ec;
    return v;
  endfunction

  task automatic check(input string name, input int s,
                       input int got, input int want);
    total++;
    if (got == want) passed++;
    else $display("FAIL %s step %0d: got %0d want %0d", name, s, got, want);
  endtask

  task automatic apply(input vec_t v);
    exp_t e;
    exp_t g;
    rst_n = v.rst_n; clr = v.clr; en = v.en; x = v.x;
    run_len = v.len; mode = v.mode;
    if (!v.rst_n) exp_evt = 0;
    else if (v.h) begin
`ifdef RUN_DETECT_EVENT_CNT_EN
      exp_evt++;
`endif
    end
    e.step = step; e.y = v.y; e.h = v.h; e.rb = v.rb;
    e.cnt = v.cnt; e.evt = exp_evt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("scoreboard_empty", step, 0, 1);
    end else begin
      g = sb.pop_front();
      check("y", g.step, int'(y), int'(g.y));
      check("hit", g.step, int'(hit), int'(g.h));
      check("run_bit", g.step, int'(run_bit), int'(g.rb));
      check("run_cnt", g.step, int'(run_cnt), int'(g.cnt));
      check("event_cnt", g.step, int'(event_cnt), g.evt);
    end
    step++;
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; en = 1'b0; x = 1'b0;
    run_len = 4'd0; mode = 2'b00;
    @(posedge clk);
    #1;

    // rst, clr, en, x, len, mode | y, hit, run_bit, run_cnt
    vecs.push_back(mk(0,0,1,1,3,2'b10, 0,0,0,0));
    vecs.push_back(mk(1,0,1,1,3,2'b10, 0,0,1,1));
    vecs.push_back(mk(1,0,1,1,3,2'b10, 0,0,1,2));
    vecs.push_back(mk(1,0,1,1,3,2'b10, 1,1,1,3));
    vecs.push_back(mk(1,0,1,1,3,2'b10, 1,0,1,4));
    vecs.push_back(mk(1,0,1,0,3,2'b10, 0,0,0,1));
    vecs.push_back(mk(1,1,1,1,2,2'b01, 0,0,0,0));
    vecs.push_back(mk(1,0,1,0,2,2'b01, 0,0,0,1));
    vecs.push_back(mk(1,0,0,0,2,2'b01, 0,0,0,1));
    vecs.push_back(mk(1,0,1,0,2,2'b01, 1,1,0,2));
    vecs.push_back(mk(1,0,1,1,0,2'b11, 1,1,1,1));
    vecs.push_back(mk(1,0,1,0,0,2'b11, 1,1,0,1));
    vecs.push_back(mk(1,0,1,1,0,2'b11, 1,1,1,1));
    vecs.push_back(mk(1,1,1,1,3,2'b10, 0,0,0,0));
    vecs.push_back(mk(1,0,1,1,3,2'b10, 0,0,1,1));
    vecs.push_back(mk(1,0,1,1,3,2'b10, 0,0,1,2));
    vecs.push_back(mk(1,1,1,1,3,2'b10, 0,0,0,0));
    vecs.push_back(mk(1,0,1,1,3,2'b10, 0,0,1,1));
    vecs.push_back(mk(0,0,1,1,3,2'b10, 0,0,0,0));
    vecs.push_back(mk(1,0,1,1,2,2'b00, 0,0,1,1));
    vecs.push_back(mk(1,0,1,1,2,2'b00, 0,0,1,2));
    vecs.push_back(mk(1,0,0,1,2,2'b10, 0,0,1,2));
    vecs.push_back(mk(1,0,1,1,2,2'b10, 1,0,1,3));
    vecs.push_back(mk(1,0,1,1,5,2'b10, 0,0,1,4));
    vecs.push_back(mk(1,0,1,1,2,2'b10, 1,0,1,5));
    vecs.push_back(mk(1,0,1,0,1,2'b01, 1,1,0,1));
    vecs.push_back(mk(1,0,0,0,1,2'b01, 1,0,0,1));

    foreach (vecs[i]) apply(vecs[i]);

    // Saturation: a ones run of 20 against threshold 15.
    apply(mk(1,1,0,0,15,2'b11, 0,0,0,0));
    for (int i = 0; i < 20; i++) begin
      apply(mk(1,0,1,1,15,2'b11,
               (i >= 14), (i == 14), 1'b1,
               (i >= 14) ? 4'd15 : 4'(i + 1)));
    end

    // Reset mid-run, then the first sample after reset is accepted.
    apply(mk(0,0,1,1,15,2'b11, 0,0,0,0));
    apply(mk(1,0,1,0,1,2'b01, 1,1,0,1));

    if (sb.size() != 0) check("scoreboard_leftover", step, sb.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
